imem_debug_loader: RTL and testbench

//  Byte-stream command engine that initiates accesses on the instruction-memory debug port
//  (A2/WD2/WE2/RD2 of the IF-ID segment register's instruction RAM).

---
 rtl/imem_dbg_pkg.sv | 24 ++
 rtl/dbg_word_packer.sv | 57 +++++
 rtl/imem_debug_loader.sv | 204 ++++++++++++++++++++
 tb/tb_imem_debug_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_dbg_pkg.sv
// Shared definitions for the instruction-memory debug loader: command codes,
// FSM state encoding and the header length.
package imem_dbg_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [2:0] HDR_LEN   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_WRITE,
    ST_RISSUE,
    ST_RWAIT,
    ST_RSEND,
    ST_RESP
  } state_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dbg_word_packer.sv
// Byte <-> word shifter: packs incoming bytes LSB first, or shifts a loaded
// word out LSB first. cnt counts bytes moved since the last clear/load.
module dbg_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        push,
  input  logic [7:0]  push_byte,
  input  logic        pop,
  output logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic [1:0]  cnt
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  // next word/count: clear beats load beats push beats pop
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr) begin
      word_d = 32'h0000_0000;
      cnt_d  = 2'd0;
    end else if (load) begin
      word_d = load_word;
      cnt_d  = 2'd0;
    end else if (push) begin
      word_d = {push_byte, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end else if (pop) begin
      word_d = {8'h00, word_q[31:8]};
      cnt_d  = cnt_q + 2'd1;
    end else begin
      word_d = word_q;
      cnt_d  = cnt_q;
    end
  end

  // shift register state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= 32'h0000_0000;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word     = word_q;
  assign byte_out = word_q[7:0];
  assign cnt      = cnt_q;

endmodule

// File: rtl/imem_debug_loader.sv
// Byte-stream command engine that writes and reads back instruction RAM
// through its debug port, holding the CPU while a command is in flight.
module imem_debug_loader
  import imem_dbg_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] ACK_BYTE       = 8'h4B,
  parameter logic [7:0] ERR_BYTE       = 8'h45
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [31:0] dbg_addr,
  output logic [31:0] dbg_wdata,
  output logic [3:0]  dbg_we,
  input  logic [31:0] dbg_rdata,
  output logic        cpu_hold,
  output logic        err
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        live_q;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  resp_q, resp_d;
  logic        err_q, err_d;
  logic [31:0] tmo_q, tmo_d;

  logic        pk_clr, pk_load, pk_push, pk_pop;
  logic [31:0] pk_word;
  logic [7:0]  pk_byte;
  logic [1:0]  pk_cnt;

  logic        rx_fire, tx_fire, tmo_run, tmo_hit;
  logic [15:0] new_len;

  dbg_word_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pk_clr),
    .load      (pk_load),
    .load_word (dbg_rdata),
    .push      (pk_push),
    .push_byte (rx_data),
    .pop       (pk_pop),
    .word      (pk_word),
    .byte_out  (pk_byte),
    .cnt       (pk_cnt)
  );

  // live_q keeps rx_ready low while reset is being applied
  assign rx_ready  = live_q & ((state_q == ST_IDLE) | (state_q == ST_HDR) | (state_q == ST_WDATA));
  assign tx_valid  = (state_q == ST_RSEND) | (state_q == ST_RESP);
  assign tx_data   = (state_q == ST_RSEND) ? pk_byte : ((state_q == ST_RESP) ? resp_q : 8'h00);
  assign dbg_addr  = addr_q;
  assign dbg_we    = (state_q == ST_WRITE) ? 4'hF : 4'h0;
  assign dbg_wdata = (state_q == ST_WRITE) ? pk_word : 32'h0000_0000;
  assign cpu_hold  = (state_q != ST_IDLE);
  assign err       = err_q;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;
  assign tmo_run = (state_q == ST_HDR) | (state_q == ST_WDATA);
  assign tmo_hit = tmo_run & ~rx_fire & (tmo_q == TMO_LAST);
  assign new_len = {rx_data, rem_q[15:8]};

  // command FSM: next state, datapath updates and packer controls
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    hdr_cnt_d = hdr_cnt_q;
    is_wr_d   = is_wr_q;
    resp_d    = resp_q;
    err_d     = err_q;
    pk_clr    = 1'b0;
    pk_load   = 1'b0;
    pk_push   = 1'b0;
    pk_pop    = 1'b0;
    if (tmo_run && !rx_fire) tmo_d = tmo_q + 32'd1;
    else                     tmo_d = 32'd0;

    case (state_q)
      ST_IDLE: begin
        pk_clr    = 1'b1;
        hdr_cnt_d = 3'd0;
        if (rx_fire) begin
          case (rx_data)
            CMD_WRITE: begin is_wr_d = 1'b1; err_d = 1'b0; state_d = ST_HDR; end
            CMD_READ:  begin is_wr_d = 1'b0; err_d = 1'b0; state_d = ST_HDR; end
            default:   begin resp_d = ERR_BYTE; err_d = 1'b1; state_d = ST_RESP; end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (tmo_hit) begin
          pk_clr  = 1'b1;
          resp_d  = ERR_BYTE;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (rx_fire) begin
          // address arrives first (4 bytes), then the word count (2 bytes)
          if (hdr_cnt_q < 3'd4) addr_d = word_align({rx_data, addr_q[31:8]});
          else                  rem_d  = new_len;
          if (hdr_cnt_q == HDR_LEN - 3'd1) begin
            hdr_cnt_d = 3'd0;
            if (new_len == 16'd0) begin
              resp_d  = ACK_BYTE;
              state_d = is_wr_q ? ST_RESP : ST_IDLE;
            end else begin
              state_d = is_wr_q ? ST_WDATA : ST_RISSUE;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_WDATA: begin
        if (tmo_hit) begin
          pk_clr  = 1'b1;
          resp_d  = ERR_BYTE;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (rx_fire) begin
          pk_push = 1'b1;
          if (pk_cnt == 2'd3) state_d = ST_WRITE;
          else                state_d = ST_WDATA;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WRITE: begin
        addr_d = addr_q + 32'd4;
        rem_d  = rem_q - 16'd1;
        resp_d = ACK_BYTE;
        if (rem_q == 16'd1) state_d = ST_RESP;
        else                state_d = ST_WDATA;
      end
      ST_RISSUE: state_d = ST_RWAIT;
      ST_RWAIT: begin
        pk_load = 1'b1;
        state_d = ST_RSEND;
      end
      ST_RSEND: begin
        if (tx_fire) begin
          pk_pop = 1'b1;
          if (pk_cnt == 2'd3) begin
            addr_d  = addr_q + 32'd4;
            rem_d   = rem_q - 16'd1;
            state_d = (rem_q == 16'd1) ? ST_IDLE : ST_RISSUE;
          end else begin
            state_d = ST_RSEND;
          end
        end else begin
          state_d = ST_RSEND;
        end
      end
      ST_RESP: begin
        if (tx_fire) state_d = ST_IDLE;
        else         state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      addr_q    <= 32'h0000_0000;
      rem_q     <= 16'd0;
      hdr_cnt_q <= 3'd0;
      is_wr_q   <= 1'b0;
      resp_q    <= 8'h00;
      err_q     <= 1'b0;
      tmo_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      hdr_cnt_q <= hdr_cnt_d;
      is_wr_q   <= is_wr_d;
      resp_q    <= resp_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_imem_debug_loader.sv
// Randomized self-checking bench for imem_debug_loader with a command-level
// reference model and a small word RAM behind the debug port.
module tb_imem_debug_loader;

  localparam int         TMO = 64;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] ERR = 8'h45;
  localparam logic [7:0] W   = 8'h57;
  localparam logic [7:0] R   = 8'h52;

  logic        clk = 1'b0;
  logic        rst_n, rx_valid, rx_ready, tx_valid, tx_ready, cpu_hold, err;
  logic [7:0]  rx_data, tx_data;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_we;

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] ram [0:255];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] wbuf [0:7];
  logic [63:0] exp_wr[$], obs_wr[$];
  logic [7:0]  exp_tx[$], obs_tx[$];
  logic        exp_err = 1'b0;
  logic        tx_rand = 1'b0;

  imem_debug_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_we(dbg_we), .dbg_rdata(dbg_rdata),
    .cpu_hold(cpu_hold), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dbg_we != 4'h0) ram[dbg_addr[9:2]] <= dbg_wdata;
    dbg_rdata <= ram[dbg_addr[9:2]];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: write strobes, tx handshakes and tx stability while stalled
  initial begin
    logic       pend;
    logic [7:0] pdata;
    pend = 1'b0;
    pdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check_eq("tx_hold_valid", tx_valid, 1);
          check_eq("tx_hold_data", tx_data, pdata);
        end
        if (dbg_we != 4'h0) begin
          check_eq("we_full", dbg_we, 4'hF);
          obs_wr.push_back({dbg_addr, dbg_wdata});
        end
        if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
        pend = tx_valid && !tx_ready;
        pdata = tx_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("rx_accept", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((obs_tx.size() < exp_tx.size() || cpu_hold) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_done", (obs_tx.size() >= exp_tx.size()) && !cpu_hold, 1);
  endtask

  task automatic compare_queues();
    check_eq("wr_count", obs_wr.size(), exp_wr.size());
    for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) check_eq("wr_addr_data", obs_wr[i], exp_wr[i]);
    check_eq("tx_count", obs_tx.size(), exp_tx.size());
    for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++) check_eq("tx_byte", obs_tx[i], exp_tx[i]);
    obs_wr.delete(); exp_wr.delete(); obs_tx.delete(); exp_tx.delete();
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr, input logic [15:0] len);
    send_byte(cmd);
    check_eq("err_clear", err, 0);
    for (int b = 0; b < 4; b++) send_byte(addr[8*b +: 8]);
    for (int b = 0; b < 2; b++) send_byte(len[8*b +: 8]);
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [15:0] len);
    logic [31:0] a, w;
    if (cmd == W || cmd == R) begin
      exp_err = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
        a = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
        if (cmd == W) begin
          exp_wr.push_back({a, wbuf[i]});
          model_mem[a] = wbuf[i];
        end else begin
          w = model_mem.exists(a) ? model_mem[a] : 32'h0;
          for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
        end
      end
      if (cmd == W) exp_tx.push_back(ACK);
      send_hdr(cmd, addr, len);
      if (cmd == W)
        for (int i = 0; i < int'(len); i++)
          for (int b = 0; b < 4; b++) send_byte(wbuf[i][8*b +: 8]);
    end else begin
      exp_err = 1'b1;
      exp_tx.push_back(ERR);
      send_byte(cmd);
    end
    wait_done();
    compare_queues();
    check_eq("err_flag", err, exp_err);
  endtask

  initial begin
    int n, r;
    logic [7:0]  c;
    logic [31:0] ad;
    logic [15:0] ln;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rx_ready", rx_ready, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_we", dbg_we, 0);
    check_eq("rst_addr", dbg_addr, 0);
    check_eq("rst_hold", cpu_hold, 0);
    check_eq("rst_err", err, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("rx_ready_after_rst", rx_ready, 1);

    // basic write then readback with a stalling receiver
    wbuf[0] = 32'h1234_5678; wbuf[1] = 32'hDEAD_BEEF;
    run_cmd(W, 32'h0000_0010, 16'd2);
    tx_rand = 1'b1;
    run_cmd(R, 32'h0000_0010, 16'd2);
    tx_rand = 1'b0;

    // unknown command, then a write clears err
    run_cmd(8'h00, 32'h0, 16'd0);
    wbuf[0] = $urandom;
    run_cmd(W, 32'h0000_0020, 16'd1);

    // timeout in the middle of a data word
    exp_err = 1'b1;
    exp_tx.push_back(ERR);
    send_hdr(W, 32'h0000_0040, 16'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    n = 0;
    while (!tx_valid && n < TMO + 50) begin @(negedge clk); n++; end
    check_eq("tmo_latency", (n >= TMO - 1) && (n <= TMO + 1), 1);
    wait_done();
    compare_queues();
    check_eq("tmo_err", err, 1);

    // reset in the middle of a write data word
    send_hdr(W, 32'h0000_0080, 16'd2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("mid_rst_rx_ready", rx_ready, 0);
    check_eq("mid_rst_tx", {tx_valid, tx_data}, 0);
    check_eq("mid_rst_dbg", {dbg_we, dbg_addr, dbg_wdata}, 0);
    check_eq("mid_rst_hold_err", {cpu_hold, err}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("mid_rst_no_write", obs_wr.size(), 0);
    obs_wr.delete(); obs_tx.delete();
    exp_err = 1'b0;
    wbuf[0] = 32'hCAFE_F00D;
    run_cmd(W, 32'h0000_0080, 16'd1);
    run_cmd(R, 32'h0000_0080, 16'd1);

    // address wrap and forced alignment
    wbuf[0] = 32'hA5A5_0001; wbuf[1] = 32'h5A5A_0002;
    run_cmd(W, 32'hFFFF_FFFC, 16'd2);
    wbuf[0] = 32'h0BAD_F00D;
    run_cmd(W, 32'h0000_0013, 16'd1);
    run_cmd(R, 32'hFFFF_FFFC, 16'd2);
    run_cmd(R, 32'h0000_0010, 16'd1);
    run_cmd(W, 32'h0000_0100, 16'd0);
    run_cmd(R, 32'h0000_0100, 16'd0);

    // random command mix
    repeat (24) begin
      r = $urandom_range(0, 9);
      ad = 32'h100 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      ln = 16'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
      tx_rand = 1'($urandom_range(0, 1));
      if (r == 0) begin
        c = 8'($urandom);
        if (c == W || c == R) c = c ^ 8'h01;
      end else if (r <= 5) begin
        c = W;
      end else begin
        c = R;
      end
      run_cmd(c, ad, ln);
    end
    tx_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
